// File: rtl/knn_input_stage.sv
// knn_input_stage: control FSM plus elastic data pipeline in front of the KNN core.
// Start/done levels are edge-detected into pulses, k is latched per query, and
// words flow through a pipeDepth-stage valid/ready pipeline tagged with their
// dimension index. Optional input-protocol checking is built only when
// KNN_INSTAGE_PROTOCOL_CHECK_EN is defined; otherwise protocol_err is tied to 0.
`timescale 1ns/1ps

// One pipeline stage: loads the upstream word whenever it is allowed to advance.
module knn_instage_stage #(
  parameter int W  = 32,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic          v_in,
  input  logic [W-1:0]  d_in,
  input  logic [IW-1:0] idx_in,
  input  logic          last_in,
  output logic          v,
  output logic [W-1:0]  d,
  output logic [IW-1:0] idx,
  output logic          last
);

  // Stage register; payload only captured with a valid word so idle data stays put.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v    <= 1'b0;
      d    <= '0;
      idx  <= '0;
      last <= 1'b0;
    end else if (ld) begin
      v <= v_in;
      if (v_in) begin
        d    <= d_in;
        idx  <= idx_in;
        last <= last_in;
      end
    end
  end

endmodule

module knn_input_stage #(
  parameter int dataWidth          = 32,
  parameter int numberOfDimensions = 5,
  parameter int pipeDepth          = 2,
  parameter int kWidth             = 32,
  localparam int IW                = $clog2(numberOfDimensions) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 done,
  input  logic [kWidth-1:0]    k,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [dataWidth-1:0] dataValueIn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [dataWidth-1:0] dataValueOut,
  output logic [IW-1:0]        dim_index,
  output logic                 last_dim,
  output logic                 start_pulse,
  output logic [kWidth-1:0]    k_out,
  output logic                 done_pulse,
  output logic                 partial_vec,
  output logic                 busy,
  output logic                 protocol_err
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(numberOfDimensions - 1);

  state_t state_q, state_d;
  logic   start_q, done_q;
  logic   start_rise, done_rise;
  logic   start_fire, drain_fire;
  logic   accept;
  logic   empty_next;
  logic [IW-1:0] cnt;

  // Chain index 0 is the input feed, index i+1 is the output of stage i.
  logic [pipeDepth:0]                vld_pipe;
  logic [pipeDepth:0][dataWidth-1:0] dat_pipe;
  logic [pipeDepth:0][IW-1:0]        idx_pipe;
  logic [pipeDepth:0]                last_pipe;
  logic [pipeDepth-1:0]              ld;
  logic [pipeDepth-1:0]              nxt_v;

  assign start_rise = start & ~start_q;
  assign done_rise  = done & ~done_q;

  assign in_ready = (state_q == STREAM) & ld[0];
  assign accept   = in_ready & in_valid;
  assign busy     = (state_q != IDLE);

  assign vld_pipe[0]  = accept;
  assign dat_pipe[0]  = dataValueIn;
  assign idx_pipe[0]  = cnt;
  assign last_pipe[0] = (cnt == LAST_IDX);

  // Stage i may load when some stage at or after it is empty or the sink is ready;
  // written as a reduction so there is no ripple through the ld vector itself.
  for (genvar gi = 0; gi < pipeDepth; gi++) begin : g_stage
    assign ld[gi] = out_ready | ~(&vld_pipe[pipeDepth:gi+1]);

    knn_instage_stage #(.W(dataWidth), .IW(IW)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .ld     (ld[gi]),
      .v_in   (vld_pipe[gi]),
      .d_in   (dat_pipe[gi]),
      .idx_in (idx_pipe[gi]),
      .last_in(last_pipe[gi]),
      .v      (vld_pipe[gi+1]),
      .d      (dat_pipe[gi+1]),
      .idx    (idx_pipe[gi+1]),
      .last   (last_pipe[gi+1])
    );
  end

  assign out_valid    = vld_pipe[pipeDepth];
  assign dataValueOut = dat_pipe[pipeDepth];
  assign dim_index    = idx_pipe[pipeDepth];
  assign last_dim     = last_pipe[pipeDepth];

  // Post-edge occupancy, so done_pulse lands the cycle after the final handshake.
  always_comb begin
    nxt_v = '0;
    for (int i = 0; i < pipeDepth; i++)
      nxt_v[i] = ld[i] ? vld_pipe[i] : vld_pipe[i+1];
    empty_next = ~|nxt_v;
  end

  // Next-state logic: start only honoured in IDLE, done only in STREAM.
  always_comb begin
    state_d    = state_q;
    start_fire = 1'b0;
    drain_fire = 1'b0;
    case (state_q)
      IDLE: if (start_rise) begin
        start_fire = 1'b1;
        state_d    = STREAM;
      end
      STREAM: if (done_rise) state_d = DRAIN;
      DRAIN: if (empty_next) begin
        drain_fire = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Edge-detect history, pulses, k latch and dimension counter.
  // History resets high so a level already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q     <= 1'b1;
      done_q      <= 1'b1;
      start_pulse <= 1'b0;
      done_pulse  <= 1'b0;
      partial_vec <= 1'b0;
      k_out       <= '0;
      cnt         <= '0;
    end else begin
      start_q     <= start;
      done_q      <= done;
      start_pulse <= start_fire;
      done_pulse  <= drain_fire;
      partial_vec <= drain_fire & (cnt != '0);
      if (start_fire) begin
        k_out <= (k == '0) ? kWidth'(1) : k;
        cnt   <= '0;
      end else if (accept) begin
        cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
      end
    end
  end

`ifdef KNN_INSTAGE_PROTOCOL_CHECK_EN
  // Sticky flag for words offered while no query is streaming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             protocol_err <= 1'b0;
    else if (in_valid && state_q != STREAM) protocol_err <= 1'b1;
  end
`else
  assign protocol_err = 1'b0;
`endif

endmodule
